// File: rtl/qpsk_frame_receiver.sv
// qpsk_frame_receiver
// Hunts the demodulated symbol stream for the sync word. Once it is found, the
// next FRAME_SYMS valid symbols are packed LSB-first into one frame. The frame
// is passed to a single-entry output stage with a valid/ready handshake.
// The hunt for the next frame starts again while a completed frame waits.
module qpsk_frame_receiver #(
  parameter int                               SYM_W      = 2,
  parameter int                               FRAME_SYMS = 14,
  parameter int                               SYNC_SYMS  = 4,
  parameter logic [SYM_W*SYNC_SYMS-1:0]       SYNC_WORD  = 8'hD8,
  localparam int                              DATA_W     = SYM_W * FRAME_SYMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SYM_W-1:0]  sym_i,
  input  logic              sym_valid_i,
  input  logic              resync_i,
  output logic [DATA_W-1:0] frame_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic              sync_lock_o,
  output logic              overflow_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int                 SYNC_W    = SYM_W * SYNC_SYMS;
  localparam int                 FILL_W    = $clog2(SYNC_SYMS + 1);
  localparam int                 IDX_W     = $clog2(FRAME_SYMS);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(SYNC_SYMS);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(FRAME_SYMS - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              state_q;
  logic [SYNC_W-1:0]   sync_sr_q;
  logic [SYNC_W-1:0]   sync_sr_d;
  logic [FILL_W-1:0]   fill_q;
  logic [FILL_W-1:0]   fill_d;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   asm_d;
  logic [DATA_W-1:0]   frame_q;
  logic                frame_valid_q;
  logic                sync_lock_q;
  logic                overflow_q;
  logic [7:0]          frame_cnt_q;
  logic                sync_match;
  logic                xfer;
  logic                frame_done;

  // Next sync window, saturating fill count, assembly buffer with the incoming
  // symbol merged in, and the handshake/completion strobes.
  always_comb begin
    sync_sr_d  = {sync_sr_q[SYNC_W-SYM_W-1:0], sym_i};
    fill_d     = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    // Fill must cover this symbol too, so a partly flushed window never matches.
    sync_match = (sync_sr_d == SYNC_WORD) && (fill_d == FILL_FULL);
    asm_d      = asm_q;
    asm_d[idx_q*SYM_W +: SYM_W] = sym_i;
    xfer       = frame_valid_q && frame_ready_i;
    // A resync on the completing edge discards the frame.
    frame_done = (state_q == COLLECT) && sym_valid_i && !resync_i &&
                 (idx_q == IDX_LAST);
  end

  // Framing FSM and output stage. The output stage has its own register, so a
  // completed frame can wait while the next frame is hunted for and collected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      sync_sr_q     <= '0;
      fill_q        <= '0;
      idx_q         <= '0;
      asm_q         <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      sync_lock_q   <= 1'b0;
      overflow_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (xfer) begin
        frame_cnt_q   <= frame_cnt_q + 8'd1;
        frame_valid_q <= 1'b0;
      end
      // A completion is accepted when the stage is empty or drains on this
      // edge. Otherwise the new frame is dropped and the old frame is kept.
      if (frame_done) begin
        if (!frame_valid_q || xfer) begin
          frame_q       <= asm_d;
          frame_valid_q <= 1'b1;
        end else begin
          overflow_q    <= 1'b1;
        end
      end
      if (resync_i) begin
        state_q     <= HUNT;
        sync_lock_q <= 1'b0;
        idx_q       <= '0;
        fill_q      <= '0;
        sync_sr_q   <= '0;
      end else if (sym_valid_i) begin
        case (state_q)
          HUNT: begin
            sync_sr_q <= sync_sr_d;
            fill_q    <= fill_d;
            if (sync_match) begin
              state_q     <= COLLECT;
              sync_lock_q <= 1'b1;
              idx_q       <= '0;
            end
          end
          COLLECT: begin
            asm_q <= asm_d;
            if (idx_q == IDX_LAST) begin
              state_q     <= HUNT;
              sync_lock_q <= 1'b0;
              idx_q       <= '0;
              fill_q      <= '0;
              sync_sr_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;
  assign sync_lock_o   = sync_lock_q;
  assign overflow_o    = overflow_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_qpsk_frame_receiver.sv
// Bench for qpsk_frame_receiver: directed scenarios with literal expectations,
// then a randomized symbol stream checked cycle by cycle against a queue model.
module tb_qpsk_frame_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sym_i;
  logic        sym_valid_i;
  logic        resync_i;
  logic [27:0] frame_o;
  logic        frame_valid_o;
  logic        frame_ready_i;
  logic        sync_lock_o;
  logic        overflow_o;
  logic [7:0]  frame_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  qpsk_frame_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .sym_i         (sym_i),
    .sym_valid_i   (sym_valid_i),
    .resync_i      (resync_i),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .sync_lock_o   (sync_lock_o),
    .overflow_o    (overflow_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Locked flag, recent hunt symbols, collected data symbols, one output slot.
  bit          m_lock;
  bit          m_valid;
  bit          m_ovf;
  logic [27:0] m_frame;
  logic [7:0]  m_cnt;
  int          hist[$];
  int          data[$];

  task automatic model_reset();
    m_lock = 0; m_valid = 0; m_ovf = 0; m_frame = '0; m_cnt = '0;
    hist.delete(); data.delete();
  endtask

  task automatic model_step();
    bit          full;
    int          word;
    logic [27:0] f;
    if (!rst) begin
      model_reset();
      return;
    end
    full = m_valid && !frame_ready_i;
    if (m_valid && frame_ready_i) begin
      m_cnt   = m_cnt + 8'd1;
      m_valid = 0;
    end
    if (resync_i) begin
      m_lock = 0;
      hist.delete();
      data.delete();
    end else if (sym_valid_i) begin
      if (!m_lock) begin
        hist.push_back(int'(sym_i));
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
          word = hist[0] * 64 + hist[1] * 16 + hist[2] * 4 + hist[3];
          if (word == 'hD8) begin
            m_lock = 1;
            data.delete();
          end
        end
      end else begin
        data.push_back(int'(sym_i));
        if (data.size() == 14) begin
          f = '0;
          for (int k = 0; k < 14; k++) f = f | (28'(data[k]) << (2 * k));
          m_lock = 0;
          hist.delete();
          data.delete();
          if (full) m_ovf = 1;
          else begin
            m_frame = f;
            m_valid = 1;
          end
        end
      end
    end
  endtask

  // Cycle-by-cycle comparison, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    model_step();
    #1;
    n_tests++;
    if (frame_valid_o !== m_valid || sync_lock_o !== m_lock ||
        overflow_o !== m_ovf || frame_cnt_o !== m_cnt ||
        (m_valid && frame_o !== m_frame)) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got frame=%h valid=%b lock=%b ovf=%b cnt=%0d expected frame=%h valid=%b lock=%b ovf=%b cnt=%0d",
               $time, frame_o, frame_valid_o, sync_lock_o, overflow_o, frame_cnt_o,
               m_frame, m_valid, m_lock, m_ovf, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one symbol slot at a falling edge; returns at the next falling edge.
  task automatic cyc(input int s, input bit v);
    sym_i       = 2'(s);
    sym_valid_i = v;
    @(negedge clk);
  endtask

  task automatic send_sync();
    cyc(3, 1); cyc(1, 1); cyc(2, 1); cyc(0, 1);
  endtask

  task automatic send_n(input int s, input int n);
    for (int i = 0; i < n; i++) cyc(s, 1);
  endtask

  int pend[$];

  task automatic refill();
    if ($urandom_range(0, 2) != 0) begin
      pend.push_back(3); pend.push_back(1); pend.push_back(2); pend.push_back(0);
      for (int i = 0; i < 14; i++) pend.push_back(int'($urandom_range(0, 3)));
    end else begin
      int n;
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) pend.push_back(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    int  s;
    bit  v;
    bit  stall;
    rst = 1'b0; sym_i = '0; sym_valid_i = 1'b0; resync_i = 1'b0; frame_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(frame_valid_o), 32'd0);
    chk("rst_lock",  32'(sync_lock_o),   32'd0);
    chk("rst_ovf",   32'(overflow_o),    32'd0);
    chk("rst_cnt",   32'(frame_cnt_o),   32'd0);
    chk("rst_frame", 32'(frame_o),       32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame
    frame_ready_i = 1'b1;
    cyc(3, 1); cyc(1, 1); cyc(2, 1);
    chk("t1_nolock", 32'(sync_lock_o), 32'd0);
    cyc(0, 1);
    chk("t1_lock", 32'(sync_lock_o), 32'd1);
    send_n(1, 13);
    chk("t1_not_yet", 32'(frame_valid_o), 32'd0);
    cyc(1, 1);
    chk("t1_valid", 32'(frame_valid_o), 32'd1);
    chk("t1_frame", 32'(frame_o), 32'h5555555);
    chk("t1_model", 32'(m_frame), 32'h5555555);
    chk("t1_unlock", 32'(sync_lock_o), 32'd0);
    cyc(0, 0);
    chk("t1_cnt", 32'(frame_cnt_o), 32'd1);
    chk("t1_drained", 32'(frame_valid_o), 32'd0);

    // Noise before sync
    cyc(0, 1); cyc(3, 1); cyc(3, 1); cyc(1, 1); cyc(2, 1);
    cyc(3, 1); cyc(1, 1); cyc(2, 1);
    chk("t2_nolock", 32'(sync_lock_o), 32'd0);
    cyc(0, 1);
    chk("t2_lock", 32'(sync_lock_o), 32'd1);
    for (int k = 0; k < 14; k++) cyc(k % 4, 1);
    chk("t2_frame", 32'(frame_o), 32'h4E4E4E4);
    chk("t2_model", 32'(m_frame), 32'h4E4E4E4);
    cyc(0, 0);
    chk("t2_cnt", 32'(frame_cnt_o), 32'd2);

    // Completion on the same edge as a transfer
    frame_ready_i = 1'b0;
    send_sync(); send_n(2, 14);
    chk("t4_a_valid", 32'(frame_valid_o), 32'd1);
    chk("t4_a_frame", 32'(frame_o), 32'hAAAAAAA);
    send_sync(); send_n(1, 13);
    frame_ready_i = 1'b1;
    cyc(1, 1);
    chk("t4_valid", 32'(frame_valid_o), 32'd1);
    chk("t4_frame", 32'(frame_o), 32'h5555555);
    chk("t4_ovf", 32'(overflow_o), 32'd0);
    chk("t4_cnt", 32'(frame_cnt_o), 32'd3);
    cyc(0, 0);
    chk("t4_cnt2", 32'(frame_cnt_o), 32'd4);

    // Resync at data symbol 7
    send_sync(); send_n(3, 7);
    resync_i = 1'b1;
    cyc(3, 1);
    resync_i = 1'b0;
    chk("t5_unlock", 32'(sync_lock_o), 32'd0);
    send_n(3, 6);
    chk("t5_no_partial", 32'(frame_valid_o), 32'd0);
    send_sync(); send_n(2, 14);
    chk("t5_frame", 32'(frame_o), 32'hAAAAAAA);
    cyc(0, 0);
    chk("t5_cnt", 32'(frame_cnt_o), 32'd5);

    // Overflow: two frames while the consumer stalls
    frame_ready_i = 1'b0;
    send_sync(); send_n(3, 14);
    send_sync(); send_n(0, 14);
    chk("t3_frame", 32'(frame_o), 32'hFFFFFFF);
    chk("t3_ovf", 32'(overflow_o), 32'd1);
    chk("t3_valid", 32'(frame_valid_o), 32'd1);
    frame_ready_i = 1'b1;
    cyc(0, 0);
    chk("t3_cnt", 32'(frame_cnt_o), 32'd6);
    chk("t3_valid0", 32'(frame_valid_o), 32'd0);
    chk("t3_sticky", 32'(overflow_o), 32'd1);

    // Valid gaps, then asynchronous reset mid-collect
    send_sync();
    for (int k = 0; k < 14; k++) begin
      cyc(int'($urandom_range(0, 3)), 0);
      cyc(k % 4, 1);
    end
    chk("t6_gap_frame", 32'(frame_o), 32'h4E4E4E4);
    chk("t6_gap_valid", 32'(frame_valid_o), 32'd1);
    send_sync(); send_n(1, 5);
    chk("t6_locked", 32'(sync_lock_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_lock",  32'(sync_lock_o),   32'd0);
    chk("t6_rst_valid", 32'(frame_valid_o), 32'd0);
    chk("t6_rst_cnt",   32'(frame_cnt_o),   32'd0);
    chk("t6_rst_ovf",   32'(overflow_o),    32'd0);
    chk("t6_rst_frame", 32'(frame_o),       32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_n(1, 14);
    chk("t6_hunt_after_rst", 32'(frame_valid_o), 32'd0);

    // Randomized stream
    for (int c = 0; c < 4000; c++) begin
      stall         = ((c / 300) % 2) == 1;
      frame_ready_i = stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
      resync_i      = ($urandom_range(0, 99) == 0);
      rst           = ($urandom_range(0, 999) != 0);
      v             = ($urandom_range(0, 3) != 0);
      if (v) begin
        if (pend.size() == 0) refill();
        s = pend.pop_front();
      end else begin
        s = int'($urandom_range(0, 3));
      end
      cyc(s, v);
    end
    rst = 1'b1; resync_i = 1'b0; frame_ready_i = 1'b1;
    repeat (2) cyc(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
